// File: rtl/alut_mem_pkg11.sv
// Shared defaults, enums and helpers for the dual-port ALUT memory.
// Optional write-first bypass is selected with ALUT_MEM_BYPASS_EN.
package alut_mem_pkg11;

  localparam int DW_DEF = 83;
  localparam int DD_DEF = 256;

  // Every bit of a cleared entry takes this value.
  localparam logic CLEAR_BIT = 1'b0;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    WR_WR = 2'd1,
    WR_RD = 2'd2
  } coll_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Classify a same-cycle access pair on the two ports.
  function automatic coll_e classify(input logic acc_a, input logic wr_a,
                                     input logic acc_b, input logic wr_b,
                                     input logic same);
    coll_e kind;
    kind = NONE;
    if (acc_a && acc_b && same) begin
      case ({wr_a, wr_b})
        2'b11:        kind = WR_WR;
        2'b10, 2'b01: kind = WR_RD;
        default:      kind = NONE;
      endcase
    end else begin
      kind = NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/alut_mem_rd_pipe11.sv
// Per-port read pipeline: RD_LAT stages, output hold register and the
// optional write-first bypass mux (ALUT_MEM_BYPASS_EN).
module alut_mem_rd_pipe11
  import alut_mem_pkg11::*;
#(
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_acc,
  input  logic [DW-1:0] arr_data,
  input  logic          byp_sel,
  input  logic [DW-1:0] byp_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  logic [DW-1:0] sel_s;

`ifdef ALUT_MEM_BYPASS_EN
  assign sel_s = byp_sel ? byp_data : arr_data;
`else
  logic unused_byp_s;
  assign unused_byp_s = ^{byp_sel, byp_data};
  assign sel_s        = arr_data;
`endif

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] s1_data_r;
      logic          s1_valid_r;

      // first stage captures the array word at the accepting edge
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data_r  <= '0;
          s1_valid_r <= 1'b0;
        end else begin
          s1_valid_r <= rd_acc;
          if (rd_acc) s1_data_r <= sel_s;
        end
      end

      // output register only loads on a valid stage, otherwise holds
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= s1_valid_r;
          if (s1_valid_r) rd_data <= s1_data_r;
        end
      end
    end else begin : g_lat1
      // single registered stage doubles as the hold register
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) rd_data <= sel_s;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/alut_mem_dp11.sv
// Dual-port ALUT storage with post-reset clear sweep and deterministic
// same-address handling; ALUT_MEM_BYPASS_EN selects write-first reads.
module alut_mem_dp11
  import alut_mem_pkg11::*;
#(
  parameter  int DW     = DW_DEF,
  parameter  int DD     = DD_DEF,
  parameter  int RD_LAT = 1,
  localparam int AW     = $clog2(DD)
) (
  input  logic          pclk11,
  input  logic          p_reset11,
  input  logic          mem_en_add11,
  input  logic          mem_write_add11,
  input  logic [AW-1:0] mem_addr_add11,
  input  logic [DW-1:0] mem_write_data_add11,
  input  logic          mem_en_age11,
  input  logic          mem_write_age11,
  input  logic [AW-1:0] mem_addr_age11,
  input  logic [DW-1:0] mem_write_data_age11,
  output logic [DW-1:0] mem_read_data_add11,
  output logic          mem_read_valid_add11,
  output logic [DW-1:0] mem_read_data_age11,
  output logic          mem_read_valid_age11,
  output logic          mem_init_busy11,
  output logic          mem_collision11
);

  // DD is a power of two, so the last index is all ones in the low AW bits.
  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  logic [DW-1:0] mem [DD];
  state_e        state_r;
  logic [AW:0]   cnt_r;
  logic          busy_r;
  logic          coll_r;

  logic  acc_add_s, acc_age_s, wr_add_s, wr_age_s, rd_add_s, rd_age_s, same_s;
  logic  byp_add_s, byp_age_s;
  coll_e coll_type_s;

  assign acc_add_s   = mem_en_add11 & ~busy_r & ~p_reset11;
  assign acc_age_s   = mem_en_age11 & ~busy_r & ~p_reset11;
  assign wr_add_s    = acc_add_s & mem_write_add11;
  assign wr_age_s    = acc_age_s & mem_write_age11;
  assign rd_add_s    = acc_add_s & ~mem_write_add11;
  assign rd_age_s    = acc_age_s & ~mem_write_age11;
  assign same_s      = (mem_addr_add11 == mem_addr_age11);
  assign coll_type_s = classify(acc_add_s, mem_write_add11, acc_age_s, mem_write_age11, same_s);
  assign byp_add_s   = (coll_type_s == WR_RD) & rd_add_s;
  assign byp_age_s   = (coll_type_s == WR_RD) & rd_age_s;

  // clear-sweep sequencer; busy drops on the edge that clears the last entry
  always_ff @(posedge pclk11) begin
    if (p_reset11) begin
      state_r <= INIT;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        INIT: begin
          if (cnt_r == LAST_IDX) begin
            state_r <= READY;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + {{AW{1'b0}}, 1'b1};
          end
        end
        READY: busy_r <= 1'b0;
        default: begin
          state_r <= INIT;
          cnt_r   <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // array update: sweep clear, then port writes with add winning a clash
  always_ff @(posedge pclk11) begin
    if (busy_r) begin
      if (!p_reset11) mem[cnt_r[AW-1:0]] <= {DW{CLEAR_BIT}};
    end else begin
      if (wr_age_s && !(wr_add_s && same_s)) mem[mem_addr_age11] <= mem_write_data_age11;
      if (wr_add_s) mem[mem_addr_add11] <= mem_write_data_add11;
    end
  end

  // collision flag reports the clash one cycle after it happens
  always_ff @(posedge pclk11) begin
    if (p_reset11) coll_r <= 1'b0;
    else           coll_r <= (coll_type_s == WR_WR);
  end

  assign mem_init_busy11 = busy_r;
  assign mem_collision11 = coll_r;

  alut_mem_rd_pipe11 #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_add (
    .clk      (pclk11),
    .rst      (p_reset11),
    .rd_acc   (rd_add_s),
    .arr_data (mem[mem_addr_add11]),
    .byp_sel  (byp_add_s),
    .byp_data (mem_write_data_age11),
    .rd_data  (mem_read_data_add11),
    .rd_valid (mem_read_valid_add11)
  );

  alut_mem_rd_pipe11 #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_age (
    .clk      (pclk11),
    .rst      (p_reset11),
    .rd_acc   (rd_age_s),
    .arr_data (mem[mem_addr_age11]),
    .byp_sel  (byp_age_s),
    .byp_data (mem_write_data_add11),
    .rd_data  (mem_read_data_age11),
    .rd_valid (mem_read_valid_age11)
  );

endmodule

// File: tb/tb_alut_mem_dp11.sv
// Bench for alut_mem_dp11: RD_LAT=1 and RD_LAT=2 instances on shared stimulus,
// checked against an array/history model; honours ALUT_MEM_BYPASS_EN.
module tb_alut_mem_dp11;

  localparam int DW = 83;
  localparam int DD = 256;
  localparam int AW = 8;
  localparam int HN = 8192;

`ifdef ALUT_MEM_BYPASS_EN
  localparam logic [DW-1:0] WR_RD_EXP = 83'hBB;
`else
  localparam logic [DW-1:0] WR_RD_EXP = 83'hAA;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en_add, wr_add, en_age, wr_age;
  logic [AW-1:0] a_add, a_age;
  logic [DW-1:0] d_add, d_age;

  logic [DW-1:0] rdd1_add, rdd1_age, rdd2_add, rdd2_age;
  logic          rdv1_add, rdv1_age, rdv2_add, rdv2_age;
  logic          busy1, busy2, coll1, coll2;

  alut_mem_dp11 #(.DW(DW), .DD(DD), .RD_LAT(1)) u_dut1 (
    .pclk11(clk), .p_reset11(rst),
    .mem_en_add11(en_add), .mem_write_add11(wr_add), .mem_addr_add11(a_add), .mem_write_data_add11(d_add),
    .mem_en_age11(en_age), .mem_write_age11(wr_age), .mem_addr_age11(a_age), .mem_write_data_age11(d_age),
    .mem_read_data_add11(rdd1_add), .mem_read_valid_add11(rdv1_add),
    .mem_read_data_age11(rdd1_age), .mem_read_valid_age11(rdv1_age),
    .mem_init_busy11(busy1), .mem_collision11(coll1)
  );

  alut_mem_dp11 #(.DW(DW), .DD(DD), .RD_LAT(2)) u_dut2 (
    .pclk11(clk), .p_reset11(rst),
    .mem_en_add11(en_add), .mem_write_add11(wr_add), .mem_addr_add11(a_add), .mem_write_data_add11(d_add),
    .mem_en_age11(en_age), .mem_write_age11(wr_age), .mem_addr_age11(a_age), .mem_write_data_age11(d_age),
    .mem_read_data_add11(rdd2_add), .mem_read_valid_add11(rdv2_add),
    .mem_read_data_age11(rdd2_age), .mem_read_valid_age11(rdv2_age),
    .mem_init_busy11(busy2), .mem_collision11(coll2)
  );

  // Model: array contents plus a per-edge history of accepted reads.
  logic [DW-1:0] mdl [DD];
  bit            hv_add [HN];
  bit            hv_age [HN];
  logic [DW-1:0] hd_add [HN];
  logic [DW-1:0] hd_age [HN];
  logic [DW-1:0] ra_m, rg_m;
  int            t = 0, last_rst = 0, sweep_n = 0, rt = 0;
  bit            busy_m = 1'b1, coll_m = 1'b0;
  bit            exp_v [2][2];
  logic [DW-1:0] exp_d [2][2];
  logic [AW-1:0] raddr [4];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, t);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at edge %0d", nm, act, exp, t);
    end
  endtask

  // model update at each rising edge
  initial forever begin
    @(posedge clk);
    t++;
    if (rst) begin
      busy_m = 1'b1; sweep_n = 0; last_rst = t; coll_m = 1'b0;
    end else if (busy_m) begin
      mdl[sweep_n] = '0;
      sweep_n++;
      if (sweep_n == DD) busy_m = 1'b0;
      coll_m = 1'b0;
    end else begin
      ra_m = mdl[a_add];
      rg_m = mdl[a_age];
`ifdef ALUT_MEM_BYPASS_EN
      if (en_age && wr_age && a_age == a_add) ra_m = d_age;
      if (en_add && wr_add && a_age == a_add) rg_m = d_add;
`endif
      hv_add[t] = en_add && !wr_add; hd_add[t] = ra_m;
      hv_age[t] = en_age && !wr_age; hd_age[t] = rg_m;
      coll_m = en_add && wr_add && en_age && wr_age && (a_add == a_age);
      if (en_age && wr_age) mdl[a_age] = d_age;
      if (en_add && wr_add) mdl[a_add] = d_add;
    end
    for (int li = 0; li < 2; li++) begin
      rt = t - li;
      if (rst) begin
        exp_v[li][0] = 1'b0; exp_v[li][1] = 1'b0;
        exp_d[li][0] = '0;   exp_d[li][1] = '0;
      end else begin
        exp_v[li][0] = (rt > last_rst) && hv_add[rt];
        exp_v[li][1] = (rt > last_rst) && hv_age[rt];
        if (exp_v[li][0]) exp_d[li][0] = hd_add[rt];
        if (exp_v[li][1]) exp_d[li][1] = hd_age[rt];
      end
    end
  end

  // compare every DUT output against the model on the falling edge
  initial forever begin
    @(negedge clk);
    if (t > 0) begin
      chk1("busy_l1", busy1, busy_m);
      chk1("busy_l2", busy2, busy_m);
      chk1("coll_l1", coll1, coll_m);
      chk1("coll_l2", coll2, coll_m);
      chk1("vld_l1_add", rdv1_add, exp_v[0][0]);
      chk1("vld_l1_age", rdv1_age, exp_v[0][1]);
      chk1("vld_l2_add", rdv2_add, exp_v[1][0]);
      chk1("vld_l2_age", rdv2_age, exp_v[1][1]);
      chk("dat_l1_add", rdd1_add, exp_d[0][0]);
      chk("dat_l1_age", rdd1_age, exp_d[0][1]);
      chk("dat_l2_add", rdd2_add, exp_d[1][0]);
      chk("dat_l2_age", rdd2_age, exp_d[1][1]);
    end
  end

  task automatic idle();
    en_add = 1'b0; wr_add = 1'b0; a_add = '0; d_add = '0;
    en_age = 1'b0; wr_age = 1'b0; a_age = '0; d_age = '0;
  endtask

  task automatic drv_add(input logic e, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    en_add = e; wr_add = w; a_add = a; d_add = d;
  endtask

  task automatic drv_age(input logic e, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    en_age = e; wr_age = w; a_age = a; d_age = d;
  endtask

  task automatic release_and_count(output int n);
    rst = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy1 && n < DD + 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    raddr[0] = 8'd0; raddr[1] = 8'd1; raddr[2] = 8'd128; raddr[3] = 8'd255;
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy1, 1'b1);
    chk("rst_rdata", rdd1_add, 83'h0);
    chk1("rst_valid", rdv2_age, 1'b0);
    chk1("rst_coll", coll1, 1'b0);

    release_and_count(n);
    chk("busy_len", DW'(n), DW'(DD));

    for (int i = 0; i < 4; i++) begin
      drv_add(1'b1, 1'b0, raddr[i], '0);
      drv_age(1'b1, 1'b0, raddr[3-i], '0);
      @(negedge clk);
      if (i == 0) begin
        chk1("rd0_valid", rdv1_add, 1'b1);
        chk("rd0_zero", rdd1_add, 83'h0);
      end
    end
    idle();
    repeat (2) @(negedge clk);

    drv_add(1'b1, 1'b1, 8'd5, 83'h0_1234_5678);
    @(negedge clk);
    idle();
    drv_age(1'b1, 1'b0, 8'd5, '0);
    @(negedge clk);
    idle();
    chk1("w5r_l1_v", rdv1_age, 1'b1);
    chk("w5r_l1_d", rdd1_age, 83'h0_1234_5678);
    chk1("w5r_l2_early", rdv2_age, 1'b0);
    @(negedge clk);
    chk1("w5r_l2_v", rdv2_age, 1'b1);
    chk("w5r_l2_d", rdd2_age, 83'h0_1234_5678);

    drv_add(1'b1, 1'b1, 8'h20, 83'h1);
    drv_age(1'b1, 1'b1, 8'h20, 83'h2);
    @(negedge clk);
    idle();
    chk1("coll_pulse", coll1, 1'b1);
    @(negedge clk);
    chk1("coll_drop", coll1, 1'b0);
    drv_age(1'b1, 1'b0, 8'h20, '0);
    @(negedge clk);
    idle();
    chk("coll_keep_add", rdd1_age, 83'h1);

    drv_add(1'b1, 1'b1, 8'd7, 83'hAA);
    @(negedge clk);
    drv_add(1'b1, 1'b1, 8'd7, 83'hBB);
    drv_age(1'b1, 1'b0, 8'd7, '0);
    @(negedge clk);
    idle();
    chk("wr_rd_l1", rdd1_age, WR_RD_EXP);
    chk1("wr_rd_nocoll", coll1, 1'b0);
    @(negedge clk);
    chk("wr_rd_l2", rdd2_age, WR_RD_EXP);
    drv_add(1'b1, 1'b0, 8'd7, '0);
    drv_age(1'b1, 1'b0, 8'd7, '0);
    @(negedge clk);
    idle();
    chk("rd_rd_add", rdd1_add, 83'hBB);
    chk("rd_rd_age", rdd1_age, 83'hBB);
    @(negedge clk);

    // read accepted, then reset lands while the RD_LAT=2 result is in flight
    drv_add(1'b1, 1'b0, 8'd5, '0);
    drv_age(1'b1, 1'b0, 8'd7, '0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk1("rst_pend_v", rdv2_age, 1'b0);
    chk("rst_pend_d", rdd2_add, 83'h0);
    chk("rst_pend_d1", rdd1_age, 83'h0);
    chk1("rst_pend_busy", busy1, 1'b1);

    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      idle();
      if (k == 10) begin
        drv_add(1'b1, 1'b1, 8'd200, 83'hFF);
        drv_age(1'b1, 1'b0, 8'd200, '0);
      end
      if (k == 11) chk1("busy_rd_ignored", rdv1_age, 1'b0);
    end
    chk1("mid_sweep_busy", busy1, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_and_count(n);
    chk("busy_len2", DW'(n), DW'(DD));

    drv_add(1'b1, 1'b0, 8'd200, '0);
    drv_age(1'b1, 1'b0, 8'd5, '0);
    @(negedge clk);
    idle();
    chk1("a200_v", rdv1_add, 1'b1);
    chk("a200_zero", rdd1_add, 83'h0);
    chk("a5_cleared", rdd1_age, 83'h0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/alut_mem_dp11.md
# alut_mem_dp11

Parametrised dual-port lookup-table memory for the ALUT address and age checkers, successor to the fixed 83x256 ALUT RAM. It adds per-port enables, configurable read latency, and a post-reset clear sweep that zeroes the whole array. It also resolves same-address collisions deterministically. It sits between the address-checker FSM (port "add") and the age-checker FSM (port "age") and is the only storage in the ALUT.

## Interface
- DW, 83, entry width in bits
- DD, 256, entry depth (power of two, >= 4)
- AW, $clog2(DD), address width (derived, not overridden)
- RD_LAT, 1, read latency in cycles (legal values 1 or 2)
- pclk11  in  1  APB clock; all logic is on the rising edge
- p_reset11  in  1  synchronous, active-high reset
- mem_en_add11 / mem_en_age11  in  1  access request, port add / age
- mem_write_add11 / mem_write_age11  in  1  1 = write, 0 = read; qualified by en
- mem_addr_add11 / mem_addr_age11  in  AW  entry address
- mem_write_data_add11 / mem_write_data_age11  in  DW  write data
- mem_read_data_add11 / mem_read_data_age11  out  DW  read data; holds its value between reads
- mem_read_valid_add11 / mem_read_valid_age11  out  1  one-cycle pulse when read data is updated
- mem_init_busy11  out  1  clear sweep in progress; all accesses are ignored
- mem_collision11  out  1  one-cycle pulse on a same-address write/write clash

## Operation
- Reset values while p_reset11 is high:
  - read data = 0, read valid = 0, collision = 0.
  - mem_init_busy11 = 1.
  - Sweep counter = 0.
  - Read pipelines are flushed.
- Clear sweep:
  - Starts on the first cycle after p_reset11 falls.
  - Writes 0 to address = counter each cycle, counting 0..DD-1.
  - mem_init_busy11 deasserts in the cycle after address DD-1 is written, so busy stays high for exactly DD cycles.
  - The counter is AW+1 bits wide. Its terminal test is counter == DD-1, so it never wraps.
- While busy, en on either port is ignored: no write, and no valid pulse.
- Accepted access: en = 1 and busy = 0.
  - Write: the array updates at the edge.
  - Read: data appears RD_LAT cycles later, with valid.
- Both ports accepted on the same address in the same cycle:
  - Write/write: port add's data is stored and port age's write is dropped. mem_collision11 pulses on the next cycle.
  - Write/read: the read port returns data according to the Configuration section. No collision pulse.
  - Read/read: both return the stored data. No collision pulse.
- A reset asserted mid-sweep or mid-read flushes the pipelines and drops any pending valid. The sweep restarts from 0 after reset release.

## Timing
- Read accepted at edge N:
  - RD_LAT=1: data and valid at edge N+1.
  - RD_LAT=2: data and valid at edge N+2, through an extra output register.
- Back-to-back reads on one port are supported at one per cycle with full throughput.
- A write at edge N followed by a read of the same address at edge N+1, on either port, returns the new data.
- mem_collision11 is registered: it asserts one cycle after the clashing edge, for exactly one cycle.
- The first accepted access is at edge DD+1 after reset release, counting the release edge as 0.

## Configuration
- ALUT_MEM_BYPASS_EN defined: a read that collides with a write from the other port returns the write data (write-first). A 2:1 bypass mux sits ahead of the read pipeline.
- ALUT_MEM_BYPASS_EN undefined: the read returns the array contents from before the write (read-first). There is no bypass mux.

## Structure
- Package alut_mem_pkg11 contains:
  - The DW/DD defaults.
  - The collision-type enum (NONE, WR_WR, WR_RD).
  - The clear-value constant (all zeros).
- Sub-module alut_mem_rd_pipe11, instantiated once per port, contains:
  - The RD_LAT-stage data/valid pipeline.
  - The hold register.
  - The optional bypass select.
- The top level holds the array, the sweep counter/FSM (states INIT, READY) and collision detection.

## Test plan
- Reset, then release: busy stays high for exactly DD cycles. Reads of addresses 0, 1, DD/2 and DD-1 all return 0 with valid after RD_LAT cycles.
- Port add writes 0x0_1234_5678 to address 5. On the next cycle port age reads address 5: valid and data 0x0_1234_5678 after RD_LAT. Check at RD_LAT = 1 and 2.
- Both ports write address 0x20 in the same cycle (add = 0x1, age = 0x2): mem_collision11 pulses one cycle later, and a later read returns 0x1.
- Address 7 holds 0xAA. Port add writes 0xBB while port age reads address 7 in the same cycle: age receives 0xBB with ALUT_MEM_BYPASS_EN and 0xAA without it. No collision pulse.
- Raise p_reset11 at sweep cycle 100 with a read pending: no valid is issued, outputs return to reset values, and busy stays high for a full DD cycles after the second release.
- Drive en with busy high (sweep cycle 10, write 0xFF to address 200): no valid pulse. Address 200 reads 0 after busy drops.
